// File: rtl/traffic_sequencer.sv
// traffic_sequencer: master FSM for a two-road intersection driving lamps, walk lamp and the BCD phase timer.
// Outputs are registered from next-state values so lamps, walk and the timer load change together with state_dbg.
module traffic_sequencer #(
   parameter logic [7:0] NS_GREEN_T = 8'h30,
   parameter logic [7:0] EW_GREEN_T = 8'h20,
   parameter logic [7:0] YELLOW_T   = 8'h03,
   parameter logic [7:0] ALLRED_T   = 8'h02,
   parameter logic [7:0] FLASH_T    = 8'h01
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       tmr_time_out,
   input  logic       ew_car,
   input  logic       ped_req,
   input  logic       flash_en,
   output logic       tmr_load,
   output logic [3:0] tmr_tens,
   output logic [3:0] tmr_ones,
   output logic [2:0] ns_light,
   output logic [2:0] ew_light,
   output logic       walk,
   output logic [2:0] state_dbg
);
   typedef enum logic [2:0] {INIT = 3'd0, NS_G, NS_Y, AR1, EW_G, EW_Y, AR2, FLASH} state_t;
   localparam logic [2:0] RED = 3'b100;
   localparam logic [2:0] YEL = 3'b010;
   localparam logic [2:0] GRN = 3'b001;
   localparam logic [2:0] OFF = 3'b000;
   state_t     state_q, state_d;
   logic [1:0] cnt_q, cnt_d;
   logic [7:0] dur_q, dur_d, dur_sel;
   logic [2:0] ns_q, ns_d, ew_q, ew_d;
   logic       init_q, load_q, load_d, ped_q, ped_d, blink_q, blink_d, walk_q, walk_d;
   logic       qual, fire;
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= INIT;
         cnt_q   <= 2'd0;
         dur_q   <= 8'h00;
         ns_q    <= RED;
         ew_q    <= RED;
         init_q  <= 1'b1;
         load_q  <= 1'b0;
         ped_q   <= 1'b0;
         blink_q <= 1'b0;
         walk_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         dur_q   <= dur_d;
         ns_q    <= ns_d;
         ew_q    <= ew_d;
         init_q  <= 1'b0;
         load_q  <= load_d;
         ped_q   <= ped_d;
         blink_q <= blink_d;
         walk_q  <= walk_d;
      end
   end
   always_comb begin
      // cnt_q counts cycles since the load; the timer output is stale until it reaches 2
      qual = tmr_time_out && cnt_q == 2'd2;
      state_d = state_q;
      if (qual) begin
         unique case (state_q)
            INIT:    state_d = flash_en ? FLASH : NS_G;
            NS_G:    state_d = (ew_car || ped_q || ped_req) ? NS_Y : NS_G;
            NS_Y:    state_d = AR1;
            AR1:     state_d = flash_en ? FLASH : EW_G;
            EW_G:    state_d = EW_Y;
            EW_Y:    state_d = AR2;
            AR2:     state_d = flash_en ? FLASH : NS_G;
            FLASH:   state_d = flash_en ? FLASH : INIT;
            default: state_d = INIT;
         endcase
      end
      fire = qual && !(state_q == NS_G && state_d == NS_G);
      load_d = init_q || fire;
      dur_sel = ALLRED_T;
      unique case (state_d)
         NS_G:       dur_sel = NS_GREEN_T;
         EW_G:       dur_sel = EW_GREEN_T;
         NS_Y, EW_Y: dur_sel = YELLOW_T;
         FLASH:      dur_sel = FLASH_T;
         default:    dur_sel = ALLRED_T;
      endcase
      dur_d = load_d ? dur_sel : dur_q;
      cnt_d = load_d ? 2'd0 : (cnt_q == 2'd2 ? cnt_q : cnt_q + 2'd1);
      blink_d = blink_q ^ (fire && state_q == FLASH);
      walk_d = state_d != NS_G ? 1'b0 : (fire ? (ped_q || ped_req) : walk_q);
      ped_d = !(fire && state_d == NS_G) && (ped_q || ped_req);
      ns_d = RED;
      ew_d = RED;
      unique case (state_d)
         NS_G:    ns_d = GRN;
         NS_Y:    ns_d = YEL;
         EW_G:    ew_d = GRN;
         EW_Y:    ew_d = YEL;
         FLASH: begin
            ns_d = blink_d ? YEL : OFF;
            ew_d = blink_d ? RED : OFF;
         end
         default: ;
      endcase
   end
   assign tmr_load  = load_q;
   assign tmr_tens  = dur_q[7:4];
   assign tmr_ones  = dur_q[3:0];
   assign ns_light  = ns_q;
   assign ew_light  = ew_q;
   assign walk      = walk_q;
   assign state_dbg = state_q;
endmodule
